// File: rtl/aoi22_fault_cov_engine_pkg.sv
// Shared definitions for the AOI22 stuck-at fault-coverage engine:
// net numbering, FSM states, vector-source modes, LFSR taps and the gate evaluator.
package aoi22_fsim_pkg;

  localparam logic [2:0] NET_A  = 3'd0;
  localparam logic [2:0] NET_B  = 3'd1;
  localparam logic [2:0] NET_C  = 3'd2;
  localparam logic [2:0] NET_D  = 3'd3;
  localparam logic [2:0] NET_AB = 3'd4;
  localparam logic [2:0] NET_CD = 3'd5;
  localparam logic [2:0] NET_OR = 3'd6;
  localparam logic [2:0] NET_Y  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic MODE_EXH  = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SEED = 16'h0001;

  function automatic logic [5:0] fault_index(input logic [1:0] ch, input logic sa1,
                                             input logic [2:0] net);
    return {ch, sa1, net};
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  // Y of one AOI22 copy; when flt is set, net fnet is forced to fval.
  function automatic logic aoi22_eval(input logic [3:0] abcd, input logic flt,
                                      input logic [2:0] fnet, input logic fval);
    logic a, b, c, d, ab, cd, orv;
    a   = (flt && fnet == NET_A)  ? fval : abcd[3];
    b   = (flt && fnet == NET_B)  ? fval : abcd[2];
    c   = (flt && fnet == NET_C)  ? fval : abcd[1];
    d   = (flt && fnet == NET_D)  ? fval : abcd[0];
    ab  = (flt && fnet == NET_AB) ? fval : (a & b);
    cd  = (flt && fnet == NET_CD) ? fval : (c & d);
    orv = (flt && fnet == NET_OR) ? fval : (ab | cd);
    return (flt && fnet == NET_Y) ? fval : ~orv;
  endfunction

endpackage

// File: rtl/aoi22_fault_cov_engine_slice.sv
// One AOI22 channel: fault-free Y plus the detect flag of each of the 16
// single stuck-at copies, all evaluated combinationally from one vector.
module aoi22_fault_slice
  import aoi22_fsim_pkg::*;
(
  input  logic [3:0] abcd,
  output logic       y,
  output logic [7:0] det_sa0,
  output logic [7:0] det_sa1
);

  always_comb begin
    y       = aoi22_eval(abcd, 1'b0, NET_A, 1'b0);
    det_sa0 = '0;
    det_sa1 = '0;
    for (int unsigned n = 0; n < 8; n++) begin
      det_sa0[n] = aoi22_eval(abcd, 1'b1, 3'(n), 1'b0) ^ y;
      det_sa1[n] = aoi22_eval(abcd, 1'b1, 3'(n), 1'b1) ^ y;
    end
  end

endmodule

// File: rtl/aoi22_fault_cov_engine.sv
// Parallel stuck-at coverage engine: vector generator, run FSM, sticky
// coverage, first-detect index per fault and a registered readback port.
module aoi22_fault_cov_engine
  import aoi22_fsim_pkg::*;
#(
  parameter int unsigned NUM_CH = 1,
  parameter int unsigned IDX_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  MODE,
  input  logic [IDX_W-1:0]      VEC_COUNT,
  input  logic [15:0]           SEED,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*NUM_CH-1:0]   PATTERN,
  output logic [8*NUM_CH-1:0]   DETECT_SA0,
  output logic [8*NUM_CH-1:0]   DETECT_SA1,
  output logic [8*NUM_CH-1:0]   COV_SA0,
  output logic [8*NUM_CH-1:0]   COV_SA1,
  output logic [6:0]            COV_COUNT,
  input  logic [5:0]            RD_SEL,
  output logic [IDX_W-1:0]      RD_IDX,
  output logic                  RD_HIT
);

  localparam int unsigned PW = 4 * NUM_CH;
  localparam int unsigned DW = 8 * NUM_CH;
  localparam int unsigned NF = 16 * NUM_CH;

  state_t            state;
  logic              mode_q;
  logic              zero_run;
  logic [IDX_W-1:0]  count_q;
  logic [IDX_W-1:0]  idx;
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_nxt;
  logic [15:0]       seed_eff;
  logic [IDX_W-1:0]  first_idx [64];

  logic [NUM_CH-1:0] y_good;
  logic [DW-1:0]     det0_w;
  logic [DW-1:0]     det1_w;
  logic [63:0]       hit_new;
  logic [63:0]       cov_flat;
  logic              rd_ok;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [7:0] s0, s1;
    aoi22_fault_slice u_slice (
      .abcd    (PATTERN[4*g +: 4]),
      .y       (y_good[g]),
      .det_sa0 (s0),
      .det_sa1 (s1)
    );
    // Y stuck at v is visible exactly when fault-free Y is ~v; gating keeps that explicit
    assign det0_w[8*g +: 8] = {s0[7] & y_good[g],  s0[6:0]};
    assign det1_w[8*g +: 8] = {s1[7] & ~y_good[g], s1[6:0]};
  end

  assign lfsr_nxt = lfsr_step(lfsr);
  assign seed_eff = (SEED == '0) ? LFSR_ZERO_SEED : SEED;
  assign rd_ok    = ({1'b0, RD_SEL} < 7'(NF));

  // Per-fault view indexed as 16c + 8t + n, matching RD_SEL.
  always_comb begin
    hit_new  = '0;
    cov_flat = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned n = 0; n < 8; n++) begin
        hit_new[fault_index(2'(c), 1'b0, 3'(n))]  = det0_w[8*c + n] & ~COV_SA0[8*c + n];
        hit_new[fault_index(2'(c), 1'b1, 3'(n))]  = det1_w[8*c + n] & ~COV_SA1[8*c + n];
        cov_flat[fault_index(2'(c), 1'b0, 3'(n))] = COV_SA0[8*c + n];
        cov_flat[fault_index(2'(c), 1'b1, 3'(n))] = COV_SA1[8*c + n];
      end
    end
  end

  always_comb begin
    COV_COUNT = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      COV_COUNT = COV_COUNT + 7'(COV_SA0[i]) + 7'(COV_SA1[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      PATTERN    <= '0;
      DETECT_SA0 <= '0;
      DETECT_SA1 <= '0;
      COV_SA0    <= '0;
      COV_SA1    <= '0;
      RD_IDX     <= '0;
      RD_HIT     <= 1'b0;
      mode_q     <= MODE_EXH;
      zero_run   <= 1'b0;
      count_q    <= '0;
      idx        <= '0;
      lfsr       <= '0;
      for (int unsigned f = 0; f < 64; f++) first_idx[f] <= '0;
    end else begin
      RD_HIT <= rd_ok & cov_flat[RD_SEL];
      RD_IDX <= rd_ok ? first_idx[RD_SEL] : '0;

      case (state)
        ST_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            mode_q     <= MODE;
            count_q    <= VEC_COUNT;
            idx        <= '0;
            lfsr       <= seed_eff;
            DETECT_SA0 <= '0;
            DETECT_SA1 <= '0;
            COV_SA0    <= '0;
            COV_SA1    <= '0;
            for (int unsigned f = 0; f < 64; f++) first_idx[f] <= '0;
            if (VEC_COUNT != '0) begin
              state   <= ST_RUN;
              BUSY    <= 1'b1;
              PATTERN <= (MODE == MODE_LFSR) ? seed_eff[PW-1:0] : '0;
            end else begin
              state    <= ST_DONE;
              zero_run <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          DETECT_SA0 <= det0_w;
          DETECT_SA1 <= det1_w;
          COV_SA0    <= COV_SA0 | det0_w;
          COV_SA1    <= COV_SA1 | det1_w;
          for (int unsigned f = 0; f < 64; f++) begin
            if (hit_new[f]) first_idx[f] <= idx;
          end
          if (idx == count_q - 1'b1) begin
            state <= ST_DRAIN;
          end else begin
            idx     <= idx + 1'b1;
            lfsr    <= lfsr_nxt;
            PATTERN <= (mode_q == MODE_LFSR) ? lfsr_nxt[PW-1:0] : PATTERN + 1'b1;
          end
        end

        ST_DRAIN: begin
          state <= ST_DONE;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
        end

        ST_DONE: begin
          // An empty run waits one extra cycle so DONE lands two cycles after START.
          if (zero_run) begin
            zero_run <= 1'b0;
            DONE     <= 1'b1;
          end else begin
            state <= ST_IDLE;
            DONE  <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aoi22_fault_cov_engine.sv
// Bench for aoi22_fault_cov_engine: a 1-channel and a 2-channel instance, a
// run-level reference model checked every cycle, plus literal expectations.
module tb_aoi22_fault_cov_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, mode, sel;
  logic [7:0]  vec_count;
  logic [15:0] seed;
  logic [5:0]  rd_sel;

  logic        busy1, done1, rdh1;
  logic [3:0]  pat1;
  logic [7:0]  d01, d11, c01, c11, rdi1;
  logic [6:0]  cnt1;
  logic        busy2, done2, rdh2;
  logic [7:0]  pat2, rdi2;
  logic [15:0] d02, d12, c02, c12;
  logic [6:0]  cnt2;

  aoi22_fault_cov_engine #(.NUM_CH(1), .IDX_W(8)) dut1 (
    .CLK(clk), .RST(rst), .START(start & ~sel), .MODE(mode), .VEC_COUNT(vec_count),
    .SEED(seed), .BUSY(busy1), .DONE(done1), .PATTERN(pat1), .DETECT_SA0(d01),
    .DETECT_SA1(d11), .COV_SA0(c01), .COV_SA1(c11), .COV_COUNT(cnt1),
    .RD_SEL(rd_sel), .RD_IDX(rdi1), .RD_HIT(rdh1));

  aoi22_fault_cov_engine #(.NUM_CH(2), .IDX_W(8)) dut2 (
    .CLK(clk), .RST(rst), .START(start & sel), .MODE(mode), .VEC_COUNT(vec_count),
    .SEED(seed), .BUSY(busy2), .DONE(done2), .PATTERN(pat2), .DETECT_SA0(d02),
    .DETECT_SA1(d12), .COV_SA0(c02), .COV_SA1(c12), .COV_COUNT(cnt2),
    .RD_SEL(rd_sel), .RD_IDX(rdi2), .RD_HIT(rdh2));

  logic        cur_busy, cur_done, cur_rdh;
  logic [7:0]  cur_pat, cur_rdi;
  logic [15:0] cur_d0, cur_d1, cur_c0, cur_c1;
  logic [6:0]  cur_cnt;
  assign cur_busy = sel ? busy2 : busy1;
  assign cur_done = sel ? done2 : done1;
  assign cur_pat  = sel ? pat2  : {4'h0, pat1};
  assign cur_d0   = sel ? d02   : {8'h00, d01};
  assign cur_d1   = sel ? d12   : {8'h00, d11};
  assign cur_c0   = sel ? c02   : {8'h00, c01};
  assign cur_c1   = sel ? c12   : {8'h00, c11};
  assign cur_cnt  = sel ? cnt2  : cnt1;
  assign cur_rdi  = sel ? rdi2  : rdi1;
  assign cur_rdh  = sel ? rdh2  : rdh1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int          nch, nvec, run_t, mstate;
  bit          chk_on;
  logic [7:0]  vecs  [256];
  logic [15:0] mdet0 [256];
  logic [15:0] mdet1 [256];

  function automatic logic ref_y(input logic [3:0] v, input int fnet, input logic fv);
    logic n [8];
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: n[k] = v[3];
        1: n[k] = v[2];
        2: n[k] = v[1];
        3: n[k] = v[0];
        4: n[k] = n[0] & n[1];
        5: n[k] = n[2] & n[3];
        6: n[k] = n[4] | n[5];
        default: n[k] = ~n[6];
      endcase
      if (k == fnet) n[k] = fv;
    end
    return n[7];
  endfunction

  task automatic model_prepare(input int n, input logic m, input logic [15:0] sd);
    logic [15:0] s;
    logic [3:0]  v;
    logic        good;
    s = (sd == 16'h0) ? 16'h0001 : sd;
    for (int i = 0; i < n; i++) begin
      vecs[i]  = (m ? s[7:0] : 8'(i)) & ((nch == 1) ? 8'h0F : 8'hFF);
      s        = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
      mdet0[i] = '0;
      mdet1[i] = '0;
      for (int c = 0; c < nch; c++) begin
        v    = vecs[i][4*c +: 4];
        good = ref_y(v, -1, 1'b0);
        for (int k = 0; k < 8; k++) begin
          mdet0[i][8*c + k] = (ref_y(v, k, 1'b0) != good);
          mdet1[i][8*c + k] = (ref_y(v, k, 1'b1) != good);
        end
      end
    end
  endtask

  task automatic model_first(input int f, output logic [7:0] fidx, output logic fhit);
    int c, t, k;
    logic b;
    c = f / 16; t = (f / 8) % 2; k = f % 8;
    fidx = '0; fhit = 1'b0;
    if (c < nch) begin
      for (int i = 0; i < nvec; i++) begin
        b = t ? mdet1[i][8*c + k] : mdet0[i][8*c + k];
        if (b && !fhit) begin
          fhit = 1'b1;
          fidx = 8'(i);
        end
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  int          ck, cj, cnt_e;
  logic [15:0] e_d0, e_d1, e_c0, e_c1;
  always @(negedge clk) begin
    if (chk_on) begin
      if (mstate == 0) begin
        check("idle_busy", cur_busy, 0);
        check("idle_done", cur_done, 0);
        check("idle_pat", cur_pat, 0);
        check("idle_det0", cur_d0, 0);
        check("idle_det1", cur_d1, 0);
        check("idle_cov0", cur_c0, 0);
        check("idle_cov1", cur_c1, 0);
        check("idle_cnt", cur_cnt, 0);
      end else begin
        ck = cyc - run_t;
        cj = (ck - 1 < nvec) ? ck - 1 : nvec;
        if (cj < 0) cj = 0;
        e_d0 = (cj > 0) ? mdet0[cj-1] : '0;
        e_d1 = (cj > 0) ? mdet1[cj-1] : '0;
        e_c0 = '0; e_c1 = '0;
        for (int i = 0; i < cj; i++) begin
          e_c0 |= mdet0[i];
          e_c1 |= mdet1[i];
        end
        cnt_e = $countones(e_c0) + $countones(e_c1);
        check("busy", cur_busy, (nvec > 0 && ck >= 1 && ck <= nvec + 1) ? 1 : 0);
        check("done", cur_done, (ck == nvec + 2) ? 1 : 0);
        if (nvec > 0 && ck >= 1)
          check("pattern", cur_pat, vecs[(ck - 1 < nvec) ? ck - 1 : nvec - 1]);
        check("det_sa0", cur_d0, e_d0);
        check("det_sa1", cur_d1, e_d1);
        check("cov_sa0", cur_c0, e_c0);
        check("cov_sa1", cur_c1, e_c1);
        check("cov_count", cur_cnt, cnt_e);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_run(input int n, input logic m, input logic [15:0] sd);
    vec_count = 8'(n); mode = m; seed = sd;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_prepare(n, m, sd);
    nvec = n; run_t = cyc - 1; mstate = 1;
  endtask

  task automatic wait_done(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk); #1;
      if (cur_done) found = 1'b1;
    end
    check(name, found ? cyc : -1, run_t + nvec + 2);
  endtask

  task automatic rd_check(input string name, input int f, input logic [7:0] ei, input logic eh);
    rd_sel = 6'(f);
    @(posedge clk); #1;
    check({name, "_idx"}, cur_rdi, ei);
    check({name, "_hit"}, cur_rdh, eh);
  endtask

  task automatic rd_sweep();
    logic [7:0] fi;
    logic       fh;
    for (int f = 0; f < 64; f++) begin
      model_first(f, fi, fh);
      rd_check("rd_sweep", f, fi, fh);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mstate = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; sel = 1'b0;
    vec_count = '0; seed = '0; rd_sel = '0;
    nch = 1; nvec = 0; run_t = 0; mstate = 0; chk_on = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_on = 1'b1;
    check("rst_busy", cur_busy, 0);
    check("rst_cnt", cur_cnt, 0);
    check("rst_rd_idx", cur_rdi, 0);

    // exhaustive, 16 vectors
    start_run(16, 1'b0, 16'h0);
    wait_done("done_t18");
    check("full_cov0", cur_c0, 16'h00FF);
    check("full_cov1", cur_c1, 16'h00FF);
    check("full_cnt", cur_cnt, 16);
    rd_check("y_sa0", 7, 8'd0, 1'b1);
    rd_check("y_sa1", 15, 8'd3, 1'b1);
    rd_check("a_sa0", 0, 8'd12, 1'b1);
    rd_check("a_sa1", 8, 8'd4, 1'b1);
    rd_sweep();

    // exhaustive, 4 vectors: A/B nets never toggle, AB never 1
    start_run(4, 1'b0, 16'h0);
    wait_done("done_n4");
    check("n4_cnt", cur_cnt, 11);
    rd_check("ab_sa0", 4, 8'd0, 1'b0);
    rd_check("a_sa0_n4", 0, 8'd0, 1'b0);
    rd_check("b_sa0_n4", 1, 8'd0, 1'b0);
    rd_check("a_sa1_n4", 8, 8'd0, 1'b0);
    rd_check("b_sa1_n4", 9, 8'd0, 1'b0);
    rd_check("c_sa1_n4", 10, 8'd1, 1'b1);
    rd_check("d_sa1_n4", 11, 8'd2, 1'b1);

    // empty run
    start_run(0, 1'b0, 16'h0);
    wait_done("done_t2");
    check("zero_cnt", cur_cnt, 0);

    // START pulse mid-run must be ignored
    start_run(16, 1'b0, 16'h0);
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("done_ignored_start");
    check("ign_cnt", cur_cnt, 16);

    // reset while vector 5 is applied
    start_run(16, 1'b0, 16'h0);
    repeat (5) begin @(posedge clk); #1; end
    check("pat_before_rst", cur_pat, 8'h05);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mstate = 0;
    check("abort_busy", cur_busy, 0);
    check("abort_pat", cur_pat, 0);
    repeat (20) @(posedge clk);
    #1;
    start_run(16, 1'b0, 16'h0);
    wait_done("done_after_abort");
    check("rerun_cnt", cur_cnt, 16);

    // LFSR, one channel, nonzero seed
    start_run(20, 1'b1, 16'hACE1);
    check("lfsr1_pat0", cur_pat, 8'h01);
    @(posedge clk); #1;
    check("lfsr1_pat1", cur_pat, 8'h03);
    wait_done("done_lfsr1");
    rd_sweep();

    // two channels, LFSR with zero seed
    do_reset();
    sel = 1'b1;
    nch = 2;
    start_run(64, 1'b1, 16'h0000);
    check("lfsr2_pat0", cur_pat, 8'h01);
    @(posedge clk); #1;
    check("lfsr2_pat1", cur_pat, 8'h02);
    wait_done("done_lfsr2");
    rd_sweep();

    // two channels, exhaustive
    start_run(40, 1'b0, 16'h0);
    wait_done("done_exh2");
    rd_sweep();

    repeat (3) @(posedge clk);
    #1;
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
